// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM pipeline stage:
//   - funct3 encodings for load/store size and signedness
//   - mem_state_t, the access sequencer states
//   - small helpers that turn (funct3, address, data) into alignment,
//     byte-strobe and lane-replicated store data
// No ports; imported by stage_memory_access and load_align_extend.
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // funct3[1:0] carries the access size (00 byte, 01 half, 1x word);
  // funct3[2] only selects zero extension and never affects alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

  // Byte enables for a store, positioned at the addressed lane.
  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated into every lane so the memory only needs the
  // strobes to pick the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// ---------------------------------------------------------------------------
// load_align_extend
// Purely combinational load formatter: picks the addressed byte or halfword
// out of a 32-bit memory word and sign- or zero-extends it per funct3.
// Ports:
//   i_word     in  32  word returned by the data memory
//   i_addr_lo  in   2  byte offset within the word
//   i_funct3   in   3  access size/sign (B, H, W, BU, HU)
//   o_data     out 32  aligned, extended load result
// ---------------------------------------------------------------------------
module load_align_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Shift the addressed lane down to bit 0, then extend from there.
  always_comb begin
    w_shifted = i_word >> {i_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = w_shifted[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/stage_memory_access.sv
// ---------------------------------------------------------------------------
// stage_memory_access
// MEM pipeline stage. Turns a load/store from the EX/MEM register into a
// valid/ready request plus one-cycle response on the data memory port,
// stalls the pipe while the access is outstanding and hands aligned,
// extended load data to MEM/WB. Non-memory instructions pass straight
// through with no added latency.
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before the access is aborted
// Ports:
//   clk, reset (async, active-low)
//   in_alu_out, in_mem_in_data, in_funct3, in_mem_read, in_mem_write,
//   in_rd, in_mem_to_reg, in_write_enable          EX/MEM register contents
//   mem_req_valid/ready/addr/we/wdata/wstrb         request channel
//   mem_resp_valid, mem_resp_rdata                  response channel
//   out_stall                                       freeze upstream stages
//   out_read_data, out_alu_out, out_rd,
//   out_mem_to_reg, out_write_enable                to MEM/WB
//   out_misaligned, out_bus_error                   access faults
// ---------------------------------------------------------------------------
module stage_memory_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_in_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_stall,
  output logic [31:0] out_read_data,
  output logic [31:0] out_alu_out,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic        out_misaligned,
  output logic        out_bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t  r_state;
  logic [CW-1:0] r_timer;
  logic [31:0] r_rdata;
  logic        r_bus_error;
  logic [31:0] r_req_addr;
  logic        r_req_we;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_wstrb;

  logic        w_access;
  logic        w_is_load;
  logic        w_misaligned;
  logic        w_go;
  logic        w_timer_expired;
  logic [31:0] w_load_data;

  // A read wins when both read and write are set, so the access is a store
  // only when mem_read is low.
  assign w_access        = in_mem_read | in_mem_write;
  assign w_is_load       = in_mem_read;
  assign w_misaligned    = is_misaligned(in_funct3, in_alu_out[1:0]);
  assign w_go            = w_access & ~w_misaligned;
  assign w_timer_expired = (r_timer == CW'(TIMEOUT_CYCLES - 1));

  // Access sequencer. Request fields are latched on leaving IDLE so they
  // stay stable for the whole handshake. The timer counts cycles spent in
  // REQ+WAIT; a response arriving on the final allowed WAIT cycle still
  // completes normally, otherwise the expiring cycle aborts to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer     <= '0;
          r_bus_error <= 1'b0;
          if (w_go) begin
            r_state     <= REQ;
            r_req_addr  <= {in_alu_out[31:2], 2'b00};
            r_req_we    <= ~w_is_load;
            r_req_wdata <= w_is_load ? 32'h0 : store_lanes(in_funct3, in_mem_in_data);
            r_req_wstrb <= w_is_load ? 4'h0 : store_strobe(in_funct3, in_alu_out[1:0]);
          end
        end
        REQ: begin
          if (w_timer_expired) begin
            r_state     <= DONE;
            r_bus_error <= 1'b1;
            r_timer     <= '0;
          end else begin
            r_timer <= r_timer + CW'(1);
            if (mem_req_ready) begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            r_state <= DONE;
            r_timer <= '0;
            if (!r_req_we) begin
              r_rdata <= mem_resp_rdata;
            end
          end else if (w_timer_expired) begin
            r_state     <= DONE;
            r_bus_error <= 1'b1;
            r_timer     <= '0;
          end else begin
            r_timer <= r_timer + CW'(1);
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_timer     <= '0;
          r_bus_error <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  load_align_extend u_align (
    .i_word    (r_rdata),
    .i_addr_lo (in_alu_out[1:0]),
    .i_funct3  (in_funct3),
    .o_data    (w_load_data)
  );

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = r_req_addr;
  assign mem_req_we    = r_req_we;
  assign mem_req_wdata = r_req_wdata;
  assign mem_req_wstrb = r_req_wstrb;

  // Stall and misalignment are qualified by reset so that a pending access
  // sitting in EX/MEM cannot hold the pipe while the stage is in reset.
  assign out_stall      = reset & w_go & (r_state != DONE);
  assign out_misaligned = reset & (r_state == IDLE) & w_access & w_misaligned;
  assign out_bus_error  = r_bus_error;
  assign out_read_data  = w_load_data;

  assign out_alu_out      = in_alu_out;
  assign out_rd           = in_rd;
  assign out_mem_to_reg   = in_mem_to_reg;
  assign out_write_enable = in_write_enable & ~out_misaligned & ~r_bus_error;

endmodule
